// File: rtl/crc_fcs_inserter.sv
// Buffers frame words alongside a CRC engine and re-emits each frame on a valid/ready
// stream with the engine's CRC appended as a trailing full-width FCS beat.
module crc_fcs_inserter #(
    parameter int DIN_WIDTH      = 32,
    parameter int LAST_DIN_WIDTH = 16,
    parameter int WIDTH          = 32,
    parameter int DATA_DEPTH     = 64,
    parameter int CRC_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic                   din_valid,
    input  logic                   din_first,
    input  logic                   din_last,
    input  logic [WIDTH-1:0]       crc_out,
    input  logic                   crc_out_valid,
    output logic [DIN_WIDTH-1:0]   dout,
    output logic [DIN_WIDTH/8-1:0] dout_keep,
    output logic                   dout_first,
    output logic                   dout_last,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overflow
);

    localparam int KEEP_W     = DIN_WIDTH / 8;
    localparam int LAST_BYTES = LAST_DIN_WIDTH / 8;
    localparam int DA_W       = $clog2(DATA_DEPTH);
    localparam int CA_W       = $clog2(CRC_DEPTH);

    localparam logic [KEEP_W-1:0] KEEP_ALL  = '1;
    localparam logic [KEEP_W-1:0] KEEP_LAST = ~(KEEP_ALL >> LAST_BYTES);

    typedef struct packed {
        logic [DIN_WIDTH-1:0] data;
        logic                 first;
        logic                 last;
    } data_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FCS
    } state_t;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    data_entry_t          data_mem [DATA_DEPTH];
    logic [WIDTH-1:0]     crc_mem  [CRC_DEPTH];

    logic [DA_W:0]        data_wr_ptr, data_rd_ptr, data_count;
    logic [CA_W:0]        crc_wr_ptr, crc_rd_ptr;
    logic [DA_W-1:0]      data_rd_addr;

    logic                 data_full, data_empty, data_avail;
    logic                 crc_full, crc_empty;
    logic                 in_frame;
    logic                 data_want, data_push, data_drop, data_pop;
    logic                 crc_push, crc_drop, crc_pop;
    logic                 transfer;

    data_entry_t          data_head;
    logic [WIDTH-1:0]     crc_head;

    // ------------------------------------------------------------------
    // Output register and FSM
    // ------------------------------------------------------------------
    state_t               state, state_n;
    logic [DIN_WIDTH-1:0] dout_n;
    logic [KEEP_W-1:0]    keep_n;
    logic                 first_n, last_n, valid_n;
    logic                 cur_is_last, cur_is_last_n;
    logic                 load_data, load_crc;

    assign transfer = dout_valid & dout_ready;

    // A buffered word stays in the FIFO until its beat is accepted downstream.
    assign data_pop = transfer & (state == DATA);
    assign crc_pop  = transfer & (state == FCS);

    assign data_empty = (data_wr_ptr == data_rd_ptr);
    assign data_full  = (data_wr_ptr[DA_W] != data_rd_ptr[DA_W]) &&
                        (data_wr_ptr[DA_W-1:0] == data_rd_ptr[DA_W-1:0]);
    assign crc_empty  = (crc_wr_ptr == crc_rd_ptr);
    assign crc_full   = (crc_wr_ptr[CA_W] != crc_rd_ptr[CA_W]) &&
                        (crc_wr_ptr[CA_W-1:0] == crc_rd_ptr[CA_W-1:0]);
    assign data_count = data_wr_ptr - data_rd_ptr;

    // Words outside a frame opened by din_first are ignored, not counted as overflow.
    assign data_want = din_valid & (din_first | in_frame);
    assign data_push = data_want & (~data_full | data_pop);
    assign data_drop = data_want & data_full & ~data_pop;
    assign crc_push  = crc_out_valid & (~crc_full | crc_pop);
    assign crc_drop  = crc_out_valid & crc_full & ~crc_pop;

    // When the current beat leaves this cycle, the next beat comes from one entry further on.
    assign data_rd_addr = data_rd_ptr[DA_W-1:0] + DA_W'(data_pop);
    assign data_avail   = data_pop ? (data_count > (DA_W+1)'(1)) : ~data_empty;
    assign data_head    = data_mem[data_rd_addr];
    assign crc_head     = crc_mem[crc_rd_ptr[CA_W-1:0]];

    // NOTE: storage arrays carry no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (data_push) begin
            data_mem[data_wr_ptr[DA_W-1:0]] <= {din, din_first, din_last};
        end
        if (crc_push) begin
            crc_mem[crc_wr_ptr[CA_W-1:0]] <= crc_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            crc_wr_ptr  <= '0;
            crc_rd_ptr  <= '0;
            in_frame    <= 1'b0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + (DA_W+1)'(1);
            if (data_pop)  data_rd_ptr <= data_rd_ptr + (DA_W+1)'(1);
            if (crc_push)  crc_wr_ptr  <= crc_wr_ptr + (CA_W+1)'(1);
            if (crc_pop)   crc_rd_ptr  <= crc_rd_ptr + (CA_W+1)'(1);
            if (data_want) in_frame    <= ~din_last;
        end
    end

    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_n       = state;
        dout_n        = dout;
        keep_n        = dout_keep;
        first_n       = dout_first;
        last_n        = dout_last;
        valid_n       = dout_valid;
        cur_is_last_n = cur_is_last;
        load_data     = 1'b0;
        load_crc      = 1'b0;

        case (state)
            IDLE: begin
                if (data_avail) begin
                    load_data = 1'b1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (!dout_valid) begin
                    load_data = data_avail;
                end else if (transfer) begin
                    if (cur_is_last) begin
                        state_n = FCS;
                        if (!crc_empty) load_crc = 1'b1;
                        else            valid_n  = 1'b0;
                    end else if (data_avail) begin
                        load_data = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                    end
                end
            end
            FCS: begin
                if (!dout_valid) begin
                    load_crc = ~crc_empty;
                end else if (transfer) begin
                    if (data_avail) begin
                        load_data = 1'b1;
                        state_n   = DATA;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        if (load_data) begin
            dout_n        = data_head.data;
            keep_n        = data_head.last ? KEEP_LAST : KEEP_ALL;
            first_n       = data_head.first;
            last_n        = 1'b0;
            valid_n       = 1'b1;
            cur_is_last_n = data_head.last;
        end
        if (load_crc) begin
            dout_n        = crc_head;
            keep_n        = KEEP_ALL;
            first_n       = 1'b0;
            last_n        = 1'b1;
            valid_n       = 1'b1;
            cur_is_last_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dout        <= '0;
            dout_keep   <= '0;
            dout_first  <= 1'b0;
            dout_last   <= 1'b0;
            dout_valid  <= 1'b0;
            cur_is_last <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            dout        <= dout_n;
            dout_keep   <= keep_n;
            dout_first  <= first_n;
            dout_last   <= last_n;
            dout_valid  <= valid_n;
            cur_is_last <= cur_is_last_n;
            if (data_drop || crc_drop) overflow <= 1'b1;
        end
    end

endmodule
